// File: rtl/bnch_update_queue.sv
// Branch-resolution update queue: turns mispredict corrections and bimodal counter
// updates into BTB write packets and buffers them in a small circular FIFO.
module bnch_update_queue #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic              cpu_clock_i,
    input  logic              cpu_reset_ni,
    input  logic              rcu_excp_i,
    input  logic [29:0]       c1_btb_vpc_i,
    input  logic [31:0]       c1_btb_target_i,
    input  logic [1:0]        c1_cntr_pred_i,
    input  logic              c1_bnch_tkn_i,
    input  logic [1:0]        c1_bnch_type_i,
    input  logic              c1_bnch_present_i,
    input  logic              c1_btb_way_i,
    input  logic              c1_btb_bm_mod_i,
    output logic              btbw_valid_o,
    input  logic              btbw_ready_i,
    output logic [29:0]       btbw_vpc_o,
    output logic [29:0]       btbw_target_o,
    output logic [1:0]        btbw_type_o,
    output logic [1:0]        btbw_cntr_o,
    output logic              btbw_way_o,
    output logic              btbw_alloc_o,
    output logic              btbw_cntr_only_o,
    output logic              full_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [29:0] vpc;
        logic [29:0] target;
        logic [1:0]  btype;
        logic [1:0]  cntr;
        logic        way;
        logic        alloc;
        logic        cntr_only;
    } pkt_t;

    pkt_t              mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    pkt_t       pkt;
    logic       pkt_valid;
    logic [1:0] cntr_new;
    logic       empty;
    logic       full;
    logic       deq;
    logic       enq;
    logic       drop;

    // Counter packets that would leave a saturated counter unchanged carry no information.
    always_comb begin
        cntr_new = c1_cntr_pred_i;
        if (c1_bnch_tkn_i) begin
            if (c1_cntr_pred_i != 2'b11) cntr_new = c1_cntr_pred_i + 2'd1;
        end else begin
            if (c1_cntr_pred_i != 2'b00) cntr_new = c1_cntr_pred_i - 2'd1;
        end
    end

    always_comb begin
        pkt           = '0;
        pkt_valid     = 1'b0;
        pkt.vpc       = c1_btb_vpc_i;
        pkt.target    = c1_btb_target_i[31:2];
        pkt.btype     = c1_bnch_type_i;
        pkt.way       = c1_btb_way_i;
        if (rcu_excp_i) begin
            pkt_valid     = 1'b1;
            pkt.alloc     = c1_bnch_present_i;
            pkt.cntr_only = 1'b0;
            pkt.cntr      = (c1_bnch_type_i != 2'b00) ? 2'b11 : 2'b10;
        end else if (c1_btb_bm_mod_i) begin
            pkt_valid     = (cntr_new != c1_cntr_pred_i);
            pkt.alloc     = 1'b1;
            pkt.cntr_only = 1'b1;
            pkt.cntr      = cntr_new;
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign deq   = !empty && btbw_ready_i;
    // A full queue still accepts a packet when the head leaves on the same edge.
    assign enq   = pkt_valid && (!full || deq);
    assign drop  = pkt_valid && full && !deq;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (enq) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (deq) rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        if (drop && (drop_cnt_q != {DROP_W{1'b1}})) drop_cnt_d = drop_cnt_q + {{(DROP_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is deliberately unreset; only the pointers define what is valid.
    always_ff @(posedge cpu_clock_i) begin
        if (enq) mem_q[wr_ptr_q[AW-1:0]] <= pkt;
    end

    pkt_t head;
    assign head = mem_q[rd_ptr_q[AW-1:0]];

    assign btbw_valid_o     = !empty;
    assign btbw_vpc_o       = head.vpc;
    assign btbw_target_o    = head.target;
    assign btbw_type_o      = head.btype;
    assign btbw_cntr_o      = head.cntr;
    assign btbw_way_o       = head.way;
    assign btbw_alloc_o     = head.alloc;
    assign btbw_cntr_only_o = head.cntr_only;
    assign full_o           = full;
    assign drop_cnt_o       = drop_cnt_q;

endmodule

// File: tb/tb_bnch_update_queue.sv
// Directed and randomized checks of bnch_update_queue against a queue-based packet model.
module tb_bnch_update_queue;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              excp, bm, tkn, present, way, ready;
    logic [1:0]        pred, btype;
    logic [29:0]       vpc;
    logic [31:0]       tgt;
    logic              v_o, way_o, alloc_o, co_o, full_o;
    logic [29:0]       vpc_o, tgt_o;
    logic [1:0]        type_o, cntr_o;
    logic [DROP_W-1:0] drop_o;

    always #5 clk = ~clk;

    bnch_update_queue #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .cpu_clock_i(clk), .cpu_reset_ni(rst_n),
        .rcu_excp_i(excp), .c1_btb_vpc_i(vpc), .c1_btb_target_i(tgt),
        .c1_cntr_pred_i(pred), .c1_bnch_tkn_i(tkn), .c1_bnch_type_i(btype),
        .c1_bnch_present_i(present), .c1_btb_way_i(way), .c1_btb_bm_mod_i(bm),
        .btbw_valid_o(v_o), .btbw_ready_i(ready),
        .btbw_vpc_o(vpc_o), .btbw_target_o(tgt_o), .btbw_type_o(type_o),
        .btbw_cntr_o(cntr_o), .btbw_way_o(way_o), .btbw_alloc_o(alloc_o),
        .btbw_cntr_only_o(co_o), .full_o(full_o), .drop_cnt_o(drop_o)
    );

    typedef struct packed {
        logic [29:0] vpc;
        logic [29:0] tgt;
        logic [1:0]  typ;
        logic [1:0]  cntr;
        logic        way;
        logic        alloc;
        logic        co;
    } mpkt_t;

    mpkt_t q[$];
    int    m_drop;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", {63'd0, v_o}, {63'd0, q.size() > 0});
        chk("full", {63'd0, full_o}, {63'd0, q.size() == DEPTH});
        chk("drop", {56'd0, drop_o}, 64'(m_drop));
        if (q.size() > 0) begin
            chk("vpc", {34'd0, vpc_o}, {34'd0, q[0].vpc});
            chk("target", {34'd0, tgt_o}, {34'd0, q[0].tgt});
            chk("fields", {57'd0, type_o, cntr_o, way_o, alloc_o, co_o},
                {57'd0, q[0].typ, q[0].cntr, q[0].way, q[0].alloc, q[0].co});
        end
    endtask

    // Model of one clock edge, computed from the packet rules directly.
    task automatic model_edge();
        mpkt_t p;
        bit    have;
        bit    d;
        int    nc;
        have = 0;
        p.vpc = vpc; p.tgt = tgt[31:2]; p.typ = btype; p.way = way;
        if (excp) begin
            have = 1; p.alloc = present; p.co = 0;
            p.cntr = (btype == 2'b00) ? 2'b10 : 2'b11;
        end else if (bm) begin
            nc = tkn ? int'(pred) + 1 : int'(pred) - 1;
            if (nc > 3) nc = 3;
            if (nc < 0) nc = 0;
            p.cntr = 2'(nc); p.alloc = 1; p.co = 1;
            have = (nc != int'(pred));
        end
        d = (q.size() > 0) && ready;
        if (d) void'(q.pop_front());
        if (have) begin
            if (q.size() < DEPTH) q.push_back(p);
            else if (m_drop < 255) m_drop++;
            else m_drop = 255;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic e, input logic b, input logic pr, input logic [1:0] ty,
                         input logic tk, input logic [1:0] pd, input logic w,
                         input logic [29:0] v, input logic [31:0] t, input logic rd);
        excp = e; bm = b; present = pr; btype = ty; tkn = tk; pred = pd;
        way = w; vpc = v; tgt = t; ready = rd;
    endtask

    task automatic idle(input logic rd);
        drive(0, 0, 0, 2'b00, 0, 2'b00, 0, 30'd0, 32'd0, rd);
    endtask

    logic [DROP_W-1:0] saved_drop;

    initial begin
        rst_n = 1'b0;
        m_drop = 0;
        idle(0);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Correction, conditional branch, present
        drive(1, 0, 1, 2'b00, 1, 2'b01, 1, 30'h40, 32'h0000_1000, 0);
        cycle();
        chk("d036_target", {34'd0, tgt_o}, 64'h400);
        chk("d036_cntr", {62'd0, cntr_o}, 64'h2);
        idle(0); cycle();
        idle(1); cycle();

        // Saturated counter update discarded, then a decrement
        drive(0, 1, 0, 2'b00, 1, 2'b11, 0, 30'h77, 32'h80, 1);
        cycle();
        chk("d037_none", {63'd0, v_o}, 64'd0);
        drive(0, 1, 0, 2'b00, 0, 2'b01, 0, 30'h78, 32'h84, 0);
        cycle();
        chk("d037_cntr", {62'd0, cntr_o}, 64'd0);
        chk("d037_co", {63'd0, co_o}, 64'd1);
        idle(1); cycle();

        // Overflow: five corrections with the BTB stalled
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 2'(i), 0, 2'b00, i[0], 30'(100 + i), 32'(i * 16), 0);
            cycle();
            if (i == 3) chk("d038_full", {63'd0, full_o}, 64'd1);
        end
        chk("d038_drop", {56'd0, drop_o}, 64'd1);
        idle(1);
        for (int i = 0; i < 4; i++) cycle();

        // Full queue with simultaneous dequeue accepts the new packet
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 2'b01, 0, 2'b00, 0, 30'(200 + i), 32'(i * 4), 0);
            cycle();
        end
        saved_drop = drop_o;
        drive(1, 0, 1, 2'b10, 0, 2'b00, 1, 30'd300, 32'h3000, 1);
        cycle();
        chk("d039_full", {63'd0, full_o}, 64'd1);
        chk("d039_drop", {56'd0, drop_o}, {56'd0, saved_drop});
        idle(1);
        for (int i = 0; i < 4; i++) cycle();

        // Correction wins over counter update
        drive(1, 1, 0, 2'b00, 1, 2'b01, 1, 30'h55, 32'h5550, 0);
        cycle();
        chk("d040_alloc", {63'd0, alloc_o}, 64'd0);
        chk("d040_co", {63'd0, co_o}, 64'd0);
        idle(1); cycle();
        chk("d040_single", {63'd0, v_o}, 64'd0);

        // Asynchronous reset with three queued entries
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 2'b11, 0, 2'b00, 0, 30'(400 + i), 32'(i), 0);
            cycle();
        end
        idle(1);
        #1 rst_n = 1'b0;
        #1;
        q.delete(); m_drop = 0;
        chk("d041_valid_rst", {63'd0, v_o}, 64'd0);
        chk("d041_full_rst", {63'd0, full_o}, 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
                  1'($urandom), 2'($urandom), 1'($urandom), 30'($urandom), 32'($urandom),
                  1'($urandom_range(0, 2) == 0));
            cycle();
        end

        // Drop counter saturation
        for (int i = 0; i < 270; i++) begin
            drive(1, 0, 1, 2'b00, 0, 2'b00, 0, 30'(i), 32'(i), 0);
            cycle();
        end
        chk("drop_sat", {56'd0, drop_o}, 64'hFF);
        idle(1);
        for (int i = 0; i < 5; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bnch_update_queue.md
BNCH_UPDATE_QUEUE -- requirements
Module: bnch_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter DROP_W, default 8, width of the drop counter.
REQ-003 SHALL have port cpu_clock_i  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port cpu_reset_ni  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port rcu_excp_i  in  1  branch-unit mispredict flag, registered stage-1 output.
REQ-006 SHALL have port c1_btb_vpc_i  in  30  resolved branch PC[31:2].
REQ-007 SHALL have port c1_btb_target_i  in  32  resolved target.
REQ-008 SHALL have port c1_cntr_pred_i  in  2  bimodal counter used at prediction.
REQ-009 SHALL have port c1_bnch_tkn_i  in  1  branch resolved taken.
REQ-010 SHALL have port c1_bnch_type_i  in  2  00 cond, 01 call, 10 jump, 11 ret.
REQ-011 SHALL have port c1_bnch_present_i  in  1  branch must exist in BTB (taken or unconditional).
REQ-012 SHALL have port c1_btb_way_i  in  1  BTB way hit or chosen.
REQ-013 SHALL have port c1_btb_bm_mod_i  in  1  correct prediction, counter update request.
REQ-014 SHALL have port btbw_valid_o  out  1  head packet valid toward BTB write port.
REQ-015 SHALL have port btbw_ready_i  in  1  BTB accepts packet this cycle.
REQ-016 SHALL have ports btbw_vpc_o out 30, btbw_target_o out 30 (target[31:2]), btbw_type_o out 2, btbw_cntr_o out 2, btbw_way_o out 1, btbw_alloc_o out 1 (entry valid bit to write), btbw_cntr_only_o out 1 (write counter field only).
REQ-017 SHALL have port full_o  out  1  queue holds DEPTH entries.
REQ-018 SHALL have port drop_cnt_o  out  DROP_W  packets lost to overflow, saturating.

Function
REQ-019 Correction packet SHALL be formed when rcu_excp_i=1: alloc=c1_bnch_present_i, cntr_only=0, cntr=2'b11 if type!=00 else 2'b10, way/vpc/type/target from inputs.
REQ-020 Correction with present=0 SHALL invalidate the way (alloc=0); remaining fields still carried.
REQ-021 Counter packet SHALL be formed when c1_btb_bm_mod_i=1 and rcu_excp_i=0: cntr_only=1, alloc=1, cntr=tkn ? sat_inc(pred) : sat_dec(pred), saturating at 2'b11 and 2'b00.
REQ-022 Counter packet whose new cntr equals c1_cntr_pred_i (saturated) SHALL be discarded, not enqueued, not counted as a drop.
REQ-023 rcu_excp_i SHALL take priority over c1_btb_bm_mod_i if both asserted.
REQ-024 No packet SHALL be formed when both rcu_excp_i and c1_btb_bm_mod_i are 0.
REQ-025 Queue SHALL be circular FIFO, read/write pointers log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full when MSBs differ and index bits match, empty when equal.
REQ-026 Packet enqueued at edge N SHALL present btbw_valid_o=1 from cycle N+1; no same-cycle bypass.
REQ-027 btbw_* data SHALL be driven from head entry; stable while btbw_valid_o=1 and btbw_ready_i=0.
REQ-028 Dequeue SHALL occur on edges where btbw_valid_o=1 and btbw_ready_i=1.
REQ-029 When full, enqueue SHALL be accepted only if a dequeue occurs that same edge; otherwise packet dropped and drop_cnt_o incremented, saturating at all-ones.
REQ-030 Simultaneous enqueue and dequeue when not full and not empty SHALL leave occupancy unchanged.
REQ-031 Queue SHALL NOT respond to pipeline flushes; inputs are already filtered upstream.
REQ-032 full_o SHALL be derived combinationally from the registered pointers.

Reset
REQ-033 cpu_reset_ni=0 SHALL asynchronously clear pointers and drop_cnt_o; btbw_valid_o=0, full_o=0 immediately.
REQ-034 Entry storage SHALL NOT require reset; btbw data outputs undefined while btbw_valid_o=0.
REQ-035 Reset asserted mid-transfer SHALL discard all queued packets; no packet emitted after deassertion until a new enqueue.

Verification
REQ-036 rcu_excp_i=1, present=1, type=00, target=0x0000_1000, vpc=0x40 -> next cycle btbw_valid_o=1, alloc=1, cntr_only=0, cntr=10, target_o=0x400.
REQ-037 bm_mod=1, tkn=1, pred=11 -> nothing enqueued; pred=01, tkn=0 -> packet cntr=00, cntr_only=1.
REQ-038 btbw_ready_i=0, five corrections with DEPTH=4 -> full_o=1 after four, drop_cnt_o=1, first four drain in order once ready=1.
REQ-039 Full queue, ready=1 and new correction same cycle -> accepted, drop_cnt_o unchanged, full_o stays 1.
REQ-040 rcu_excp_i=1 and bm_mod=1 together, present=0 -> single packet alloc=0, cntr_only=0.
REQ-041 Three queued entries, cpu_reset_ni pulsed low between edges -> btbw_valid_o=0 immediately, stays 0 after release.
